// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for RAM port B with lock, starvation limit
// and 1-cycle read return. Define ARB_STATS_EN to add saturating per-requester grant counters.
module mem_port_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_HOLD = 4,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
`ifdef ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1
`endif
);

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic              last;
    logic              locked;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rd_pend;
    logic              rd_owner;

    logic gnt_any;
    logic gnt_sel;
    logic sel_we;
    logic sel_lock;
    logic other_req;

    // Arbitration: a lock only keeps the previous owner while the starvation limit allows it.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = REQ0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_any = 1'b1;
                if (locked && (hold_cnt < HOLD_MAX)) begin
                    gnt_sel = last;
                end else begin
                    gnt_sel = ~last;
                end
            end else if (req0) begin
                gnt_any = 1'b1;
                gnt_sel = REQ0;
            end else if (req1) begin
                gnt_any = 1'b1;
                gnt_sel = REQ1;
            end
        end
    end

    assign gnt0 = gnt_any && (gnt_sel == REQ0);
    assign gnt1 = gnt_any && (gnt_sel == REQ1);

    always_comb begin
        mem_addr  = '0;
        mem_data  = '0;
        mem_we    = 1'b0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        other_req = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_data  = wdata0;
            mem_we    = we0;
            sel_we    = we0;
            sel_lock  = lock0;
            other_req = req1;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_data  = wdata1;
            mem_we    = we1;
            sel_we    = we1;
            sel_lock  = lock1;
            other_req = req0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= REQ1;
            locked   <= 1'b0;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= REQ0;
        end else begin
            if (gnt_any) begin
                last     <= gnt_sel;
                locked   <= sel_lock;
                rd_pend  <= ~sel_we;
                rd_owner <= gnt_sel;
                // A repeat grant under contention only happens while hold_cnt < MAX_HOLD, so no overflow.
                if ((gnt_sel == last) && other_req) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    hold_cnt <= '0;
                end
            end else begin
                locked   <= 1'b0;
                hold_cnt <= '0;
                rd_pend  <= 1'b0;
            end
        end
    end

    // Read data comes straight from the RAM one cycle after the grant.
    assign rvalid0 = rd_pend && (rd_owner == REQ0);
    assign rvalid1 = rd_pend && (rd_owner == REQ1);
    assign rdata0  = rvalid0 ? mem_q : '0;
    assign rdata1  = rvalid1 ? mem_q : '0;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (stat_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && (gnt_cnt0 != '1)) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (gnt1 && (gnt_cnt1 != '1)) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
`endif

    a_params: assert property (@(posedge clk) (MAX_HOLD >= 1) && (STAT_W >= 1));
    a_gnt_excl: assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
    a_gnt_req: assert property (@(posedge clk) disable iff (reset) (!gnt0 || req0) && (!gnt1 || req1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter with a behavioural RAM
// and reference model; covers grant statistics when ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int MAX_HOLD = 4;
`ifdef ARB_STATS_EN
    localparam int STAT_W = 8;
`else
    localparam int STAT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [DATA_W-1:0] wdata0 = '0;
    logic              req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [DATA_W-1:0] wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DATA_W-1:0] rdata0, rdata1, mem_data;
    logic [DATA_W-1:0] mem_q = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              stat_clr = 1'b0;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return DATA_W'((32'(a) * 32'd40503) ^ 32'h00005A5A);
    endfunction

    // Behavioural single-port RAM with 1-cycle read latency; unwritten words hold init_val.
    logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
    bit                ram_wr [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        mem_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        if (mem_we) begin
            ram[mem_addr]    <= mem_data;
            ram_wr[mem_addr] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit                g0;
        bit                g1;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        longint            c0;
        longint            c1;
    } gexp_t;

    typedef struct {
        bit                owner;
        logic [DATA_W-1:0] data;
        int                due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    // Reference model: who owned the port last, whether that grant asked for a lock, and
    // how many grants in a row that owner has taken (restarting at 1 whenever nobody else waited).
    int                m_last = 1;
    bit                m_lock = 1'b0;
    int                m_streak = 1;
    longint            m_c0 = 0;
    longint            m_c1 = 0;
    logic [DATA_W-1:0] shadow [int];
    longint            cnt_max = (longint'(1) << STAT_W) - 1;

    function automatic logic [DATA_W-1:0] shadow_rd(input logic [ADDR_W-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    task automatic model_reset();
        m_last   = 1;
        m_lock   = 1'b0;
        m_streak = 1;
        m_c0     = 0;
        m_c1     = 0;
        rq.delete();
    endtask

    task automatic step(input bit rst,
                        input bit r0, input bit w0, input bit l0,
                        input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input bit r1, input bit w1, input bit l1,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input bit clr, input bit midrst);
        gexp_t e;
        int    g;
        bit    other;
        @(posedge clk);
        #1;
        reset = rst; stat_clr = clr;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        e = '{default: 0};
        if (rst) begin
            model_reset();
            gq.push_back(e);
            return;
        end
        g = -1;
        if (r0 && r1) g = (m_lock && m_streak <= MAX_HOLD) ? m_last : 1 - m_last;
        else if (r0) g = 0;
        else if (r1) g = 1;
        if (midrst) begin
            #3;
            chk("gnt_before_reset", {gnt1, gnt0}, (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00);
            reset = 1'b1;
            model_reset();
            gq.push_back(e);
            return;
        end
        e.c0 = m_c0;
        e.c1 = m_c1;
        if (g >= 0) begin
            e.g0   = (g == 0);
            e.g1   = (g == 1);
            e.we   = (g == 1) ? w1 : w0;
            e.addr = (g == 1) ? a1 : a0;
            e.data = (g == 1) ? d1 : d0;
            if (e.we) shadow[int'(e.addr)] = e.data;
            else rq.push_back('{owner: (g == 1), data: shadow_rd(e.addr), due: cyc + 1});
            other    = (g == 1) ? r0 : r1;
            m_streak = (g == m_last && other) ? m_streak + 1 : 1;
            m_last   = g;
            m_lock   = (g == 1) ? l1 : l0;
        end else begin
            m_lock   = 1'b0;
            m_streak = 1;
        end
        if (clr) begin
            m_c0 = 0;
            m_c1 = 0;
        end else begin
            if (g == 0 && m_c0 < cnt_max) m_c0++;
            if (g == 1 && m_c1 < cnt_max) m_c1++;
        end
        gq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic rnd_step(input int p_req);
        step(0, ($urandom_range(99) < p_req), ($urandom_range(99) < 30), ($urandom_range(99) < 40),
             ADDR_W'($urandom_range(31)), DATA_W'($urandom),
             ($urandom_range(99) < p_req), ($urandom_range(99) < 30), ($urandom_range(99) < 40),
             ADDR_W'($urandom_range(31)), DATA_W'($urandom), 0, 0);
    endtask

    // Monitor: one grant expectation per cycle, and read returns matched against their due cycle.
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("gnt0", gnt0, e.g0);
                chk("gnt1", gnt1, e.g1);
                chk("mem_we", mem_we, e.we);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_data", mem_data, e.data);
`ifdef ARB_STATS_EN
                chk("gnt_cnt0", gnt_cnt0, e.c0);
                chk("gnt_cnt1", gnt_cnt1, e.c1);
`endif
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                chk("rvalid", {rvalid1, rvalid0}, r.owner ? 2'b10 : 2'b01);
                chk("rdata", r.owner ? rdata1 : rdata0, r.data);
                chk("rdata_other", r.owner ? rdata0 : rdata1, 0);
            end else begin
                chk("rvalid_idle", {rvalid1, rvalid0}, 2'b00);
                chk("rdata_idle", {rdata1, rdata0}, 0);
            end
        end
    end

    initial begin
        // Reset held with both requesting: no grants, no returns.
        repeat (3) step(1, 1, 0, 1, 16'h0001, '0, 1, 0, 1, 16'h0002, '0, 0, 0);
        // Contended reads alternate, requester 0 first.
        repeat (6) step(0, 1, 0, 0, 16'h0010, DATA_W'($urandom), 1, 0, 0, 16'h0020, DATA_W'($urandom), 0, 0);
        idle();
        // Write then read-back by the other requester.
        step(0, 1, 1, 0, 16'h0005, 16'hBEEF, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 0, 0, '0, '0, 1, 0, 0, 16'h0005, '0, 0, 0);
        idle();
        idle();
        // Lock held by requester 0 against a waiting requester 1.
        repeat (8) step(0, 1, 0, 1, 16'h0007, '0, 1, 0, 0, 16'h0008, '0, 0, 0);
        idle();
        repeat (10) step(0, 0, 0, 0, '0, '0, 1, 0, 0, ADDR_W'($urandom_range(63)), '0, 0, 0);
        repeat (1500) rnd_step(75);
        repeat (500) rnd_step(95);
        idle();
        idle();
        // Read return in flight when reset hits, then reset arriving before the return.
        step(0, 1, 0, 0, 16'h0003, '0, 0, 0, 0, '0, '0, 0, 0);
        step(1, 1, 0, 0, 16'h0003, '0, 1, 0, 0, 16'h0004, '0, 0, 0);
        idle();
        step(0, 1, 0, 0, 16'h0003, '0, 0, 0, 0, '0, '0, 0, 1);
        step(1, 1, 0, 0, 16'h0003, '0, 1, 0, 0, 16'h0004, '0, 0, 0);
        repeat (3) idle();
        repeat (20) rnd_step(80);
`ifdef ARB_STATS_EN
        repeat (300) step(0, 1, 0, 0, ADDR_W'($urandom_range(31)), '0, 0, 0, 0, '0, '0, 0, 0);
        step(0, 1, 0, 0, 16'h0001, '0, 0, 0, 0, '0, '0, 1, 0);
        repeat (3) idle();
`endif
        repeat (3) idle();
        repeat (2) @(negedge clk);
        #1;
        chk("returns_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter for the shared data port (port B) of the single-clock true dual-port RAM. Requester 0 is the CPU load/store path; requester 1 is a secondary master, such as an I/O bridge or a DMA engine.
Per-cycle round-robin arbitration with an optional lock for read-modify-write sequences, plus a starvation limit.
Tracks the RAM's 1-cycle read latency and returns read data with a per-requester valid strobe. Port A (instruction fetch) is not touched.

Parameters:
DATA_W, 16, data width
ADDR_W, 16, address width
MAX_HOLD, 4, max consecutive grants to one owner while the other requester waits (>=1)
STAT_W, 16, width of grant statistics counters (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req0  in  1  requester 0 access request
we0  in  1  requester 0 write (1) / read (0)
lock0  in  1  requester 0 wants to keep ownership next cycle
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 granted this cycle
rvalid0  out  1  requester 0 read data valid
rdata0  out  DATA_W  requester 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1  as above, for requester 1
mem_addr  out  ADDR_W  to RAM addr_b
mem_data  out  DATA_W  to RAM data_b
mem_we  out  1  to RAM we_b
mem_q  in  DATA_W  from RAM q_b

Behaviour:
- Grant is combinational from the current-cycle req/lock signals and the registered state. The RAM samples mem_* at the next rising clk edge.
- At most one of gnt0/gnt1 is high. gnt=1 requires the matching req=1.
- Granted requester drives the memory port: mem_addr=addrX, mem_data=wdataX, mem_we=weX.
- With no grant: mem_we=0, mem_addr=0, mem_data=0.
- Registered state:
  - last: owner of the most recent grant; reset value 1, so requester 0 wins the first tie.
  - locked: the previous grant was made with lockX=1.
  - hold_cnt: 0..MAX_HOLD.
  - rd_pend: 1 bit.
  - rd_owner: 1 bit.
- Priority resolution:
  - Only one req high: that requester is granted.
  - Both high, locked=1 and hold_cnt<MAX_HOLD: previous owner is granted.
  - Both high, otherwise: requester != last is granted.
  - Neither high: no grant; last unchanged; locked cleared.
- hold_cnt update:
  - Increments when the same owner is granted again while the other req is high.
  - Cleared on an owner change, or when the other req is low.
  - On reaching MAX_HOLD, lock is ignored for the next arbitration and the waiting requester must be granted.
- Lock by a requester that is not granted has no effect.
- Read return:
  - A granted read (we=0) sets rd_pend=1 and rd_owner=X.
  - On the next cycle, rvalidX=1 for exactly one cycle and rdataX=mem_q. The other requester's rdata is 0.
  - Back-to-back reads give one rvalid per cycle, in grant order, even when ownership alternates.
  - Writes produce no rvalid.
- Reset values: rvalid0/1=0, rdata0/1=0, rd_pend=0, hold_cnt=0, locked=0, last=1.
- gnt outputs are 0 during reset regardless of req.
- Reset mid-operation: a pending read return is discarded, with no rvalid after reset deasserts.
- Simultaneous write and read to the same address by different requesters cannot occur, because only one port is granted per cycle.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (STAT_W each) and input stat_clr (1).
  - Each counter increments on every cycle its gnt is high.
  - Counters saturate at all-ones with no wrap.
  - stat_clr=1 synchronously zeroes both counters; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Not defined: these ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset, then req0=req1=1 both reads, addr0=0x0010, addr1=0x0020, lock=0 -> gnt0 in cycle 1, gnt1 in cycle 2, strictly alternating. rvalid0 in cycle 2 with rdata0=RAM[0x0010]; rvalid1 in cycle 3 with rdata1=RAM[0x0020].
- req0 write we0=1, addr0=0x0005, wdata0=0xBEEF; next cycle req1 read addr1=0x0005 -> mem_we=1 then 0. rvalid1 one cycle later with rdata1=0xBEEF. rvalid0 never asserted.
- req0 with lock0=1 held and req1 held, MAX_HOLD=4 -> gnt0 for 5 consecutive cycles (initial grant plus 4 holds), then gnt1 exactly once. gnt1 is not delayed further by lock0.
- Only req1 active for 10 cycles -> gnt1 every cycle, hold_cnt stays 0. rvalid1 follows each read by exactly 1 cycle.
- Granted read to addr 0x0003 followed by reset asserted asynchronously mid-cycle before the return -> rvalid0/1=0 immediately and after reset release. gnt0/gnt1 forced to 0 while reset=1.
- ARB_STATS_EN: 300 grants to requester 0 with STAT_W=8 -> gnt_cnt0=0xFF, saturated. Pulse stat_clr -> both counters 0 on the next cycle.
